// File: rtl/data_mem_if.sv
// Request/response bundle between the load/store queue and the data memory controller.
interface data_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_ack;
    logic [31:0] mem_read_val;
    logic        mem_err;
    logic        mem_busy;
    logic        mem_drop;

    modport master (
        output mem_req, mem_we, mem_addr, mem_data,
        input  mem_ack, mem_read_val, mem_err, mem_busy, mem_drop
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_data,
        output mem_ack, mem_read_val, mem_err, mem_busy, mem_drop
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Single-port word memory with programmable access latency and a one-entry pending buffer
// that absorbs a request arriving while an access is in flight.
module data_mem_ctrl #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    data_mem_if.slave  mem_if
);

    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  CntReload = 4'(LATENCY - 1);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_t        act_q, act_d;
    req_t        pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        drop_q, drop_d;
    logic [31:0] mem_q [DEPTH];

    req_t        in_req;
    logic        act_bad;
    logic [AW-1:0] act_idx;
    logic        wr_en;

    assign in_req  = '{we: mem_if.mem_we, addr: mem_if.mem_addr, data: mem_if.mem_data};
    assign act_bad = (act_q.addr[1:0] != 2'b00) ||
                     ({2'b00, act_q.addr[31:2]} >= 32'(DEPTH));
    assign act_idx = act_q.addr[AW+1:2];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        act_d      = act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        ack_d      = 1'b0;
        rdata_d    = rdata_q;
        err_d      = err_q;
        drop_d     = drop_q;
        wr_en      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (mem_if.mem_req) begin
                    act_d   = in_req;
                    cnt_d   = CntReload;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                    if (mem_if.mem_req) begin
                        if (!pend_vld_q) begin
                            pend_d     = in_req;
                            pend_vld_d = 1'b1;
                        end else begin
                            drop_d = 1'b1;
                        end
                    end
                end else begin
                    // Completion edge: the access happens here, never earlier.
                    ack_d   = 1'b1;
                    err_d   = act_bad;
                    wr_en   = act_q.we && !act_bad;
                    rdata_d = (act_q.we || act_bad) ? 32'd0 : mem_q[act_idx];
                    if (pend_vld_q) begin
                        act_d      = pend_q;
                        cnt_d      = CntReload;
                        pend_vld_d = mem_if.mem_req;
                        if (mem_if.mem_req) begin
                            pend_d = in_req;
                        end
                    end else if (mem_if.mem_req) begin
                        act_d = in_req;
                        cnt_d = CntReload;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            act_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            act_q      <= act_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (wr_en) begin
            mem_q[act_idx] <= act_q.data;
        end
    end

    assign mem_if.mem_ack      = ack_q;
    assign mem_if.mem_read_val = rdata_q;
    assign mem_if.mem_err      = err_q;
    assign mem_if.mem_busy     = pend_vld_q;
    assign mem_if.mem_drop     = drop_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Drives five controllers (LATENCY 1..5) with identical stimulus and checks each against a
// transaction-queue model of in-order service with one buffered request.
module tb_data_mem_ctrl;

    localparam int NDUT  = 5;
    localparam int DEPTH = 256;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [31:0] addr  = 32'd0;
    logic [31:0] wdata = 32'd0;

    logic        ack_w  [NDUT];
    logic [31:0] rv_w   [NDUT];
    logic        err_w  [NDUT];
    logic        busy_w [NDUT];
    logic        drop_w [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        data_mem_if bus ();
        assign bus.mem_req  = req;
        assign bus.mem_we   = we;
        assign bus.mem_addr = addr;
        assign bus.mem_data = wdata;

        data_mem_ctrl #(
            .DEPTH   (DEPTH),
            .LATENCY (g + 1)
        ) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .mem_if (bus)
        );

        assign ack_w[g]  = bus.mem_ack;
        assign rv_w[g]   = bus.mem_read_val;
        assign err_w[g]  = bus.mem_err;
        assign busy_w[g] = bus.mem_busy;
        assign drop_w[g] = bus.mem_drop;
    end

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } mreq_t;

    // Model: outstanding requests in service order; head completes at tdone.
    mreq_t       mq     [NDUT][$];
    int          tdone  [NDUT];
    logic [31:0] mmem   [NDUT][DEPTH];
    logic        e_ack  [NDUT];
    logic [31:0] e_rv   [NDUT];
    logic        e_err  [NDUT];
    logic        e_drop [NDUT];
    int          cyc;
    int          n_cmp;
    int          n_fail;

    task automatic chk(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s dut%0d (L=%0d) cyc=%0d: got %h, want %h",
                     tag, d, d + 1, cyc, obs, exp);
            $error("%s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            mq[d].delete();
            tdone[d]  = 0;
            e_ack[d]  = 1'b0;
            e_rv[d]   = 32'd0;
            e_err[d]  = 1'b0;
            e_drop[d] = 1'b0;
            for (int i = 0; i < DEPTH; i++) mmem[d][i] = 32'd0;
        end
    endtask

    task automatic model_edge(input int d, input logic r, input logic w,
                              input logic [31:0] a, input logic [31:0] dt);
        mreq_t h;
        mreq_t n;
        logic  bad;
        int    idx;
        e_ack[d] = 1'b0;
        if (mq[d].size() > 0 && cyc == tdone[d]) begin
            h   = mq[d].pop_front();
            idx = int'(h.addr[31:2]);
            bad = (h.addr[1:0] != 2'b00) || (h.addr[31:2] >= 30'(DEPTH));
            e_ack[d] = 1'b1;
            e_err[d] = bad;
            e_rv[d]  = 32'd0;
            if (!bad) begin
                if (h.we) mmem[d][idx] = h.data;
                else      e_rv[d] = mmem[d][idx];
            end
            if (mq[d].size() > 0) tdone[d] = cyc + d + 1;
        end
        if (r) begin
            if (mq[d].size() < 2) begin
                n = '{we: w, addr: a, data: dt};
                mq[d].push_back(n);
                if (mq[d].size() == 1) tdone[d] = cyc + d + 1;
            end else begin
                e_drop[d] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < NDUT; d++) begin
            chk("ack",  d, 32'(ack_w[d]),  32'(e_ack[d]));
            chk("rval", d, rv_w[d],        e_rv[d]);
            chk("err",  d, 32'(err_w[d]),  32'(e_err[d]));
            chk("busy", d, 32'(busy_w[d]), 32'(mq[d].size() == 2));
            chk("drop", d, 32'(drop_w[d]), 32'(e_drop[d]));
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] dt);
        req   = r;
        we    = w;
        addr  = a;
        wdata = dt;
        @(posedge clk);
        cyc++;
        for (int d = 0; d < NDUT; d++) model_edge(d, r, w, a, dt);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        req   = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] ra;
        int          sel;
        n_cmp  = 0;
        n_fail = 0;
        cyc    = 0;

        // Store-then-load at L=2: acks at E2 and E4, load returns stored word.
        do_reset();
        step(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        idle(1);
        step(1'b1, 1'b0, 32'h10, 32'd0);
        idle(2);
        chk("st_ld_ack", 1, 32'(ack_w[1]), 32'd1);
        chk("st_ld_val", 1, rv_w[1], 32'hDEADBEEF);
        chk("st_ld_err", 1, 32'(err_w[1]), 32'd0);
        idle(12);

        // Latency sweep: ack exactly LATENCY edges after the request edge.
        do_reset();
        step(1'b1, 1'b0, 32'h40, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            idle(1);
            for (int g = 0; g < NDUT; g++) begin
                chk("lat_ack", g, 32'(ack_w[g]), 32'(k == g + 1));
            end
        end

        // Error cases: misaligned, out of range, and an errored store.
        do_reset();
        step(1'b1, 1'b0, 32'h13, 32'd0);
        idle(6);
        for (int g = 0; g < NDUT; g++) chk("misalign_err", g, 32'(err_w[g]), 32'd1);
        step(1'b1, 1'b0, 32'h400, 32'd0);
        idle(6);
        for (int g = 0; g < NDUT; g++) chk("range_rval", g, rv_w[g], 32'd0);
        step(1'b1, 1'b1, 32'h401, 32'hFFFF_FFFF);
        idle(6);
        step(1'b1, 1'b0, 32'h0, 32'd0);
        idle(6);
        for (int g = 0; g < NDUT; g++) chk("word0_kept", g, rv_w[g], 32'd0);

        // Buffering at L=3: second request buffered, third dropped.
        do_reset();
        step(1'b1, 1'b0, 32'h4, 32'd0);
        step(1'b1, 1'b1, 32'h8, 32'h0000_00AA);
        chk("buf_busy", 2, 32'(busy_w[2]), 32'd1);
        step(1'b1, 1'b0, 32'h8, 32'd0);
        chk("buf_drop", 2, 32'(drop_w[2]), 32'd1);
        idle(12);

        // Chaining at L=2: a request on the completion edge goes to pending.
        do_reset();
        step(1'b1, 1'b1, 32'hC, 32'h5555_0001);
        step(1'b1, 1'b0, 32'hC, 32'd0);
        step(1'b1, 1'b0, 32'h10, 32'd0);
        idle(8);
        chk("chain_drop", 1, 32'(drop_w[1]), 32'd0);

        // Reset mid-store: the store must not land.
        do_reset();
        step(1'b1, 1'b1, 32'h20, 32'h0000_1234);
        idle(1);
        do_reset();
        step(1'b1, 1'b0, 32'h20, 32'd0);
        idle(6);
        chk("rst_store_lost", 3, rv_w[3], 32'd0);

        // Randomized traffic with occasional asynchronous resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                sel = int'($urandom_range(0, 15));
                if (sel == 0)      ra = {22'd0, 8'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
                else if (sel == 1) ra = {20'd0, 10'($urandom_range(256, 300)), 2'b00};
                else               ra = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                step($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), ra, $urandom);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Single-port data memory controller downstream of the load/store queue. Accepts one-cycle memory requests (`mem_req`/`mem_we`/`mem_addr`/`mem_data`), performs the word access after a programmable latency, and returns a one-cycle `mem_ack` with the read data. A one-entry pending buffer absorbs a request that arrives while an access is in flight, so the queue's single-cycle request pulses are not lost.

## Interface
- `DEPTH`, 256: number of 32-bit words; word index = `mem_addr[31:2]`.
- `LATENCY`, 2: cycles from request acceptance to `mem_ack`; legal range 1..15.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `mem_req`  in  1  request strobe, sampled each rising edge.
- `mem_we`  in  1  1 = store, 0 = load.
- `mem_addr`  in  32  byte address, must be word aligned.
- `mem_data`  in  32  store data.
- `mem_ack`  out  1  one-cycle completion pulse.
- `mem_read_val`  out  32  load data; 0 for stores and errored accesses.
- `mem_err`  out  1  valid with `mem_ack`: misaligned or out-of-range access.
- `mem_busy`  out  1  pending buffer full; a request now is dropped.
- `mem_drop`  out  1  sticky: at least one request dropped since reset.

## Operation
- State machine: IDLE, ACCESS.
- Active register holds {we, addr, data}; pending register holds {valid, we, addr, data}; 4-bit latency counter `cnt`.
- IDLE: `mem_req` high -> latch into active, `cnt <= LATENCY-1`, go ACCESS.
- ACCESS, `cnt != 0`: decrement `cnt`. `mem_req` high and pending empty -> capture into pending. `mem_req` high and pending full -> request dropped, `mem_drop <= 1`.
- ACCESS, `cnt == 0` (completion edge): perform the access, set `mem_ack <= 1`, then:
  - pending valid -> move pending to active, reload `cnt`, stay ACCESS; a simultaneous `mem_req` goes into pending (never dropped).
  - pending empty and `mem_req` high -> latch it into active, stay ACCESS.
  - otherwise -> IDLE.
- Access rules:
  - Error if `addr[1:0] != 0` or `addr[31:2] >= DEPTH`: no array write, `mem_read_val <= 0`, `mem_err <= 1`.
  - Store: `array[addr[31:2]] <= data`, `mem_read_val <= 0`.
  - Load: `mem_read_val <=` array word; `mem_err <= 0`.
- Service is strictly in order, so a load issued after a store to the same word returns the stored value.
- `mem_busy = pending.valid` (combinational from the register).

## Timing
- Reset (async, `rst_n` low): state IDLE, `cnt` 0, pending invalid, `mem_ack` 0, `mem_read_val` 0, `mem_err` 0, `mem_drop` 0, `mem_busy` 0. All array words are cleared to 0.
- Reset mid-access abandons both the active and the pending request. No ack is produced, and a store that has not reached its completion edge does not modify the array.
- `mem_ack`, `mem_read_val`, `mem_err`: registered. `mem_ack` is high for exactly one cycle. `mem_read_val` and `mem_err` hold their values until the next ack.
- Request sampled at edge E0 -> `mem_ack` high in the cycle after edge E0+LATENCY. With LATENCY=1 the ack is visible the cycle after acceptance.
- Back-to-back requests every LATENCY cycles (chained at the completion edge) produce one ack every LATENCY cycles with no bubble.
- Requests spaced closer than LATENCY: at most one is buffered. Any further request before the completion edge is dropped.

## Test plan
- Store-then-load, LATENCY=2: store addr 0x10 data 0xDEADBEEF at E0, load 0x10 at E2 -> acks at E2 and E4, second ack `mem_read_val` = 0xDEADBEEF, `mem_err` = 0.
- Latency sweep LATENCY=1,2,5: single load of unwritten word 0x40 -> ack exactly LATENCY cycles after the request edge, `mem_read_val` = 0.
- Errors: load 0x13 (misaligned) and 0x400 with DEPTH=256 -> ack with `mem_err` = 1 and `mem_read_val` = 0. Store to 0x401 leaves word 0 unchanged (a later load of 0x0 returns 0).
- Buffering, LATENCY=3: requests at E0 and E1 -> `mem_busy` high after E1, acks at E3 and E6. A third request at E2 -> dropped, `mem_drop` = 1, only two acks.
- Completion-edge chaining, LATENCY=2: request at E0, pending request at E1, new request at E2 (completion edge) -> acks at E2, E4, E6, `mem_drop` stays 0.
- Reset mid-op: store 0x20 data 0x1234 at E0, LATENCY=4, assert `rst_n` low at E2 -> no ack, all outputs 0. After release, load 0x20 returns 0.
